// File: rtl/popcount_accum.sv
// Frame accumulator for per-word population counts: sums and tracks the peak
// count over frame_words_p words, then presents the result with valid/ready.
module popcount_accum #(
  parameter int width_p       = 8,
  parameter int frame_words_p = 4
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  input  logic                                          valid_i,
  input  logic [$clog2(width_p):0]                      count_i,
  output logic                                          ready_o,
  output logic                                          valid_o,
  input  logic                                          ready_i,
  output logic [$clog2(width_p*frame_words_p+1)-1:0]    total_o,
  output logic [$clog2(width_p):0]                      max_o,
  output logic                                          err_o
);

  localparam int cnt_w = $clog2(width_p) + 1;
  localparam int tot_w = $clog2(width_p * frame_words_p + 1);
  localparam int idx_w = $clog2(frame_words_p);

  localparam logic [cnt_w-1:0] width_c = cnt_w'(width_p);
  localparam logic [idx_w-1:0] last_c  = idx_w'(frame_words_p - 1);

  localparam logic [0:0] st_accum = 1'b0;
  localparam logic [0:0] st_hold  = 1'b1;

  logic [0:0]       state_r;
  logic [tot_w-1:0] sum_r;
  logic [cnt_w-1:0] max_r;
  logic [idx_w-1:0] idx_r;
  logic [tot_w-1:0] total_r;
  logic [cnt_w-1:0] max_out_r;
  logic             err_r;

  logic [cnt_w-1:0] eff_s;
  logic [cnt_w-1:0] peak_s;
  logic [tot_w-1:0] sum_next_s;
  logic             ready_s;
  logic             in_hs_s;
  logic             out_hs_s;
  logic             bad_s;

  // Clamp the incoming count, form the handshakes and the next sum/peak.
  always_comb begin
    bad_s = 1'b0;
    eff_s = count_i;
    if (count_i > width_c) begin
      bad_s = 1'b1;
      eff_s = width_c;
    end else begin
      bad_s = 1'b0;
      eff_s = count_i;
    end

    if (state_r == st_hold) begin
      ready_s = ready_i;
    end else begin
      ready_s = 1'b1;
    end

    if (eff_s > max_r) begin
      peak_s = eff_s;
    end else begin
      peak_s = max_r;
    end

    sum_next_s = sum_r + tot_w'(eff_s);
    in_hs_s    = valid_i & ready_s;
    out_hs_s   = (state_r == st_hold) & ready_i;
  end

  // Frame state machine, running accumulators and registered results.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r   <= st_accum;
      sum_r     <= '0;
      max_r     <= '0;
      idx_r     <= '0;
      total_r   <= '0;
      max_out_r <= '0;
      err_r     <= 1'b0;
    end else begin
      if (in_hs_s && bad_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end

      case (state_r)
        st_accum: begin
          if (in_hs_s) begin
            if (idx_r == last_c) begin
              total_r   <= sum_next_s;
              max_out_r <= peak_s;
              sum_r     <= '0;
              max_r     <= '0;
              idx_r     <= '0;
              state_r   <= st_hold;
            end else begin
              sum_r <= sum_next_s;
              max_r <= peak_s;
              idx_r <= idx_r + idx_w'(1);
            end
          end
        end
        st_hold: begin
          // An input handshake in HOLD can only occur alongside the output one.
          if (out_hs_s) begin
            state_r <= st_accum;
            if (in_hs_s) begin
              sum_r <= tot_w'(eff_s);
              max_r <= eff_s;
              idx_r <= idx_w'(1);
            end else begin
              sum_r <= '0;
              max_r <= '0;
              idx_r <= '0;
            end
          end
        end
        default: begin
          state_r <= st_accum;
          sum_r   <= '0;
          max_r   <= '0;
          idx_r   <= '0;
        end
      endcase
    end
  end

  assign ready_o = ready_s;
  assign valid_o = (state_r == st_hold);
  assign total_o = total_r;
  assign max_o   = max_out_r;
  assign err_o   = err_r;

endmodule
